// File: rtl/controle_ula.sv
`default_nettype none
// ============================================================================
// Module   : controle_ula
// Purpose  : Sequences one ULA operation per start request, holds operands for
//            LAT_ULA cycles, captures result/flags and latches divide errors.
//            Optional macro ULA_ACUM_EN chains resultado[3:0] into operand A.
// Revision : 1.0 - initial release
// ============================================================================
module controle_ula #(
    parameter int LAT_ULA = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic             limpar,
    input  logic [3:0]       A_in,
    input  logic [3:0]       B_in,
    input  logic [2:0]       Sel_in,
    input  logic             usar_acum,
    output logic [3:0]       ula_A,
    output logic [3:0]       ula_B,
    output logic [2:0]       ula_Sel,
    input  logic [7:0]       ula_S,
    input  logic             ula_Z,
    input  logic             ula_OV,
    input  logic             ula_COUT,
    input  logic             ula_ERR,
    output logic [7:0]       resultado,
    output logic             Z,
    output logic             OV,
    output logic             COUT,
    output logic             ERR,
    output logic             pronto,
    output logic             valido,
    output logic [CNT_W-1:0] n_ops
);

    localparam logic [1:0] c_OCIOSO  = 2'd0;
    localparam logic [1:0] c_EXECUTA = 2'd1;
    localparam logic [1:0] c_ERRO    = 2'd2;
    localparam logic [3:0] c_CNT_INI = 4'(LAT_ULA - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       ula_a_q, ula_a_d;
    logic [3:0]       ula_b_q, ula_b_d;
    logic [2:0]       ula_sel_q, ula_sel_d;
    logic [7:0]       res_q, res_d;
    logic             z_q, z_d, ov_q, ov_d, cout_q, cout_d, err_q, err_d;
    logic             valido_q, valido_d;
    logic [CNT_W-1:0] n_ops_q, n_ops_d;
    logic             w_accept, w_capture;
    logic [3:0]       w_a_src;

    assign w_accept  = (state_q == c_OCIOSO)  && iniciar && !limpar;
    assign w_capture = (state_q == c_EXECUTA) && (cnt_q == 4'd0) && !limpar;

`ifdef ULA_ACUM_EN
    assign w_a_src = usar_acum ? res_q[3:0] : A_in;
`else
    logic w_unused_acum;
    assign w_unused_acum = usar_acum;
    assign w_a_src       = A_in;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_OCIOSO;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (limpar) begin
            state_d = c_OCIOSO;
        end else begin
            case (state_q)
                c_OCIOSO:  if (iniciar) state_d = c_EXECUTA;
                c_EXECUTA: if (cnt_q == 4'd0) state_d = ula_ERR ? c_ERRO : c_OCIOSO;
                c_ERRO:    state_d = c_ERRO;
                default:   state_d = c_OCIOSO;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        pronto = (state_q == c_OCIOSO);
    end

    // Datapath next values; limpar overrides any capture in flight
    always_comb begin
        cnt_d     = cnt_q;
        ula_a_d   = ula_a_q;
        ula_b_d   = ula_b_q;
        ula_sel_d = ula_sel_q;
        res_d     = res_q;
        z_d       = z_q;
        ov_d      = ov_q;
        cout_d    = cout_q;
        err_d     = err_q;
        n_ops_d   = n_ops_q;
        valido_d  = w_capture;

        if (w_accept) begin
            ula_a_d   = w_a_src;
            ula_b_d   = B_in;
            ula_sel_d = Sel_in;
            cnt_d     = c_CNT_INI;
        end else if ((state_q == c_EXECUTA) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (limpar) begin
            res_d  = 8'd0;
            z_d    = 1'b0;
            ov_d   = 1'b0;
            cout_d = 1'b0;
            err_d  = 1'b0;
        end else if (w_capture) begin
            if (ula_ERR) begin
                res_d  = 8'd0;
                z_d    = 1'b0;
                ov_d   = 1'b0;
                cout_d = 1'b0;
                err_d  = 1'b1;
            end else begin
                res_d   = ula_S;
                z_d     = ula_Z;
                ov_d    = ula_OV;
                cout_d  = ula_COUT;
                err_d   = 1'b0;
                n_ops_d = n_ops_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            ula_a_q   <= 4'd0;
            ula_b_q   <= 4'd0;
            ula_sel_q <= 3'd0;
            res_q     <= 8'd0;
            z_q       <= 1'b0;
            ov_q      <= 1'b0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            valido_q  <= 1'b0;
            n_ops_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ula_a_q   <= ula_a_d;
            ula_b_q   <= ula_b_d;
            ula_sel_q <= ula_sel_d;
            res_q     <= res_d;
            z_q       <= z_d;
            ov_q      <= ov_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            valido_q  <= valido_d;
            n_ops_q   <= n_ops_d;
        end
    end

    assign ula_A     = ula_a_q;
    assign ula_B     = ula_b_q;
    assign ula_Sel   = ula_sel_q;
    assign resultado = res_q;
    assign Z         = z_q;
    assign OV        = ov_q;
    assign COUT      = cout_q;
    assign ERR       = err_q;
    assign valido    = valido_q;
    assign n_ops     = n_ops_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_ula
// Purpose  : Directed + random bench for controle_ula with a stub ULA and a
//            timestamp-based transaction model (honours ULA_ACUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_ula;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0, limpar = 1'b0, usar_acum = 1'b0;
    logic [3:0] A_in = 4'd0, B_in = 4'd0;
    logic [2:0] Sel_in = 3'd0;
    logic [3:0] ula_A, ula_B;
    logic [2:0] ula_Sel;
    logic [7:0] ula_S;
    logic       ula_Z, ula_OV, ula_COUT, ula_ERR;
    logic [7:0] resultado;
    logic       Z, OV, COUT, ERR, pronto, valido;
    logic [7:0] n_ops;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    controle_ula #(.LAT_ULA(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .limpar(limpar),
        .A_in(A_in), .B_in(B_in), .Sel_in(Sel_in), .usar_acum(usar_acum),
        .ula_A(ula_A), .ula_B(ula_B), .ula_Sel(ula_Sel),
        .ula_S(ula_S), .ula_Z(ula_Z), .ula_OV(ula_OV), .ula_COUT(ula_COUT),
        .ula_ERR(ula_ERR), .resultado(resultado), .Z(Z), .OV(OV), .COUT(COUT),
        .ERR(ERR), .pronto(pronto), .valido(valido), .n_ops(n_ops)
    );

    // Stub ULA: returns {err, cout, ov, z, s[7:0]}
    function automatic logic [11:0] ula_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [4:0] t;
        logic [7:0] s;
        logic       cout, ov;
        cout = 1'b0;
        ov   = 1'b0;
        case (sel)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; s = {3'd0, t};
                        cout = t[4]; ov = (a[3] == b[3]) && (t[3] != a[3]); end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; s = {4'd0, t[3:0]};
                        cout = t[4]; ov = (a[3] != b[3]) && (t[3] != a[3]); end
            3'd2: s = {4'd0, a} * {4'd0, b};
            3'd3: begin
                if (b == 4'd0) return {4'b1111, 8'hEE};
                s = {4'd0, a / b};
            end
            3'd4: s = {4'd0, a & b};
            3'd5: s = {4'd0, a | b};
            3'd6: s = {4'd0, a ^ b};
            default: s = {4'd0, ~a};
        endcase
        return {1'b0, cout, ov, (s == 8'd0), s};
    endfunction

    always_comb {ula_ERR, ula_COUT, ula_OV, ula_Z, ula_S} = ula_fn(ula_A, ula_B, ula_Sel);

    // Reference model: an accepted op completes LAT edges after acceptance
    logic [3:0] m_a, m_b;
    logic [2:0] m_sel;
    logic [7:0] m_res, m_nops;
    logic       m_z, m_ov, m_cout, m_err, m_valido;
    bit         m_busy, m_lock;
    int         cyc, m_cap;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_nops = 0;
        m_z = 0; m_ov = 0; m_cout = 0; m_err = 0; m_valido = 0;
        m_busy = 0; m_lock = 0;
    endtask

    task automatic model_edge(input logic ini, input logic lim, input logic [3:0] a,
                              input logic [3:0] b, input logic [2:0] sel, input logic acum);
        logic [11:0] r;
        cyc++;
        m_valido = 0;
        if (lim) begin
            m_res = 0; m_z = 0; m_ov = 0; m_cout = 0; m_err = 0;
            m_busy = 0; m_lock = 0;
        end else if (m_lock) begin
            m_err = 1;
        end else if (m_busy) begin
            if (cyc == m_cap) begin
                r = ula_fn(m_a, m_b, m_sel);
                if (r[11]) begin
                    m_res = 0; m_z = 0; m_ov = 0; m_cout = 0; m_err = 1; m_lock = 1;
                end else begin
                    m_res = r[7:0]; m_z = r[8]; m_ov = r[9]; m_cout = r[10]; m_err = 0;
                    m_nops = m_nops + 8'd1;
                end
                m_valido = 1;
                m_busy   = 0;
            end
        end else if (ini) begin
`ifdef ULA_ACUM_EN
            m_a = acum ? m_res[3:0] : a;
`else
            m_a = a;
            if (acum) m_a = a;
`endif
            m_b = b; m_sel = sel;
            m_busy = 1;
            m_cap  = cyc + LAT;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ula_A", 32'(ula_A), 32'(m_a));
        check("ula_B", 32'(ula_B), 32'(m_b));
        check("ula_Sel", 32'(ula_Sel), 32'(m_sel));
        check("resultado", 32'(resultado), 32'(m_res));
        check("Z", 32'(Z), 32'(m_z));
        check("OV", 32'(OV), 32'(m_ov));
        check("COUT", 32'(COUT), 32'(m_cout));
        check("ERR", 32'(ERR), 32'(m_err));
        check("pronto", 32'(pronto), 32'(!m_busy && !m_lock));
        check("valido", 32'(valido), 32'(m_valido));
        check("n_ops", 32'(n_ops), 32'(m_nops));
    endtask

    task automatic step(input logic ini, input logic lim, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] sel, input logic acum);
        iniciar = ini; limpar = lim; A_in = a; B_in = b; Sel_in = sel; usar_acum = acum;
        @(posedge clk);
        model_edge(ini, lim, a, b, sel, acum);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, A_in, B_in, Sel_in, 1'b0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // soma 9+7
        step(1, 0, 4'h9, 4'h7, 3'd0, 0);
        check("soma_pronto_low", 32'(pronto), 32'd0);
        idle(1);
        idle(1);
        check("soma_valido", 32'(valido), 32'd1);
        check("soma_res", 32'(resultado), 32'h10);
        idle(1);

        // sub 3-3
        step(1, 0, 4'h3, 4'h3, 3'd1, 0);
        idle(2);
        check("sub_Z", 32'(Z), 32'd1);
        check("sub_pronto", 32'(pronto), 32'd1);
        idle(1);

        // div by zero, ignored iniciar, limpar
        step(1, 0, 4'h6, 4'h0, 3'd3, 0);
        idle(2);
        check("div_ERR", 32'(ERR), 32'd1);
        step(1, 0, 4'h1, 4'h1, 3'd0, 0);
        idle(3);
        check("erro_no_valido", 32'(valido), 32'd0);
        step(0, 1, 4'h1, 4'h1, 3'd0, 0);
        check("limpar_n_ops", 32'(n_ops), 32'd2);

        // switches change mid-operation
        step(1, 0, 4'h2, 4'h2, 3'd0, 0);
        step(0, 0, 4'hF, 4'h9, 3'd7, 0);
        step(0, 0, 4'hF, 4'h9, 3'd7, 0);
        check("hold_res", 32'(resultado), 32'h04);
        idle(1);

        // accumulate (A_in differs from resultado[3:0])
        step(1, 0, 4'h7, 4'h5, 3'd0, 1);
        idle(2);
        idle(1);

        // limpar one cycle after accept
        step(1, 0, 4'h4, 4'h4, 3'd2, 0);
        step(0, 1, 4'h4, 4'h4, 3'd2, 0);
        idle(3);
        // limpar with iniciar in OCIOSO
        step(1, 1, 4'h5, 4'h1, 3'd4, 0);
        idle(1);
        // limpar on the capture edge
        step(1, 0, 4'h5, 4'h1, 3'd5, 0);
        idle(1);
        step(0, 1, 4'h5, 4'h1, 3'd5, 0);
        idle(1);
        // iniciar held high
        for (int i = 0; i < 9; i++) step(1, 0, 4'(i), 4'(i + 3), 3'(i), 0);

        // asynchronous reset mid-EXECUTA
        step(1, 0, 4'hA, 4'h3, 3'd6, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        idle(1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controle_ula.md
Name: controle_ula

Overview:
- Sequencer between the operand/selector switches and the combinational ULA datapath with its flag generator.
- Accepts one operation per start request and holds A, B and Sel stable on the ULA inputs for a programmable settle time.
- Captures the 8-bit result and the Z/OV/COUT/ERR flags into registers and reports completion.
- Latches the divide-by-zero error until explicitly cleared; feeds the BCD display path and the flag LEDs.

Parameters:
- LAT_ULA, 2, cycles the ULA inputs are held before capture (legal range 1..15).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- iniciar  in  1  start request, sampled each rising edge
- limpar  in  1  synchronous clear / abort
- A_in  in  4  operand A from switches
- B_in  in  4  operand B from switches
- Sel_in  in  3  operation selector from switches
- usar_acum  in  1  chain previous result as A (meaningful only with ULA_ACUM_EN)
- ula_A  out  4  registered operand A to ULA
- ula_B  out  4  registered operand B to ULA
- ula_Sel  out  3  registered selector to ULA
- ula_S  in  8  ULA result
- ula_Z, ula_OV, ula_COUT, ula_ERR  in  1 each  flags from flag generator
- resultado  out  8  captured result
- Z, OV, COUT, ERR  out  1 each  captured flags
- pronto  out  1  ready to accept iniciar
- valido  out  1  one-cycle pulse: new resultado/flags
- n_ops  out  CNT_W  count of completed non-error operations

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State OCIOSO.
  - ula_A, ula_B, ula_Sel, resultado, Z, OV, COUT, ERR, valido and n_ops all 0; cnt=0.
  - pronto=1.
- States: OCIOSO, EXECUTA, ERRO.
- OCIOSO: pronto=1. Accept when iniciar=1 at edge E0:
  - ula_A<=A_in, ula_B<=B_in, ula_Sel<=Sel_in.
  - cnt<=LAT_ULA-1; go to EXECUTA; pronto drops at E0.
- EXECUTA: pronto=0; iniciar ignored. Each edge: if cnt!=0 then cnt<=cnt-1, else capture. Capture therefore occurs at E0+LAT_ULA:
  - If ula_ERR=0:
    - resultado<=ula_S; Z/OV/COUT<=flag inputs; ERR<=0.
    - n_ops<=n_ops+1 (wraps modulo 2^CNT_W).
    - valido<=1 for one cycle; go to OCIOSO.
  - If ula_ERR=1:
    - resultado<=0; Z, OV, COUT<=0; ERR<=1.
    - valido<=1 for one cycle; n_ops unchanged; go to ERRO.
- Back-to-back operation: pronto rises at the capture edge, so the next iniciar is accepted at E0+LAT_ULA+1 at the earliest.
- ULA inputs are not modified between accept and capture, even if switches change.
- ERRO: pronto=0; iniciar ignored; ERR held at 1 until limpar.
- limpar=1 at any edge, any state:
  - Go to OCIOSO; resultado and all four flags <=0; valido<=0.
  - n_ops is preserved; ula_* are preserved.
  - In EXECUTA this aborts the operation: no capture, no valido.
- Simultaneous limpar and iniciar in OCIOSO: limpar wins; iniciar is dropped.
- Simultaneous limpar and capture edge: limpar wins; no valido.
- iniciar held high continuously: one operation per OCIOSO visit; no edge detection is required.

Optional Feature:
- Macro ULA_ACUM_EN.
- Defined: on accept with usar_acum=1, ula_A<=resultado[3:0] instead of A_in, which allows chained accumulation. resultado[7:4] is discarded.
- Not defined: usar_acum is ignored; ula_A always <=A_in. The port remains present so integration is unchanged.

Test Plan:
- Reset, then A=9, B=7, Sel=000 (soma), pulse iniciar; LAT_ULA=2 -> pronto low for 2 cycles; valido pulses at E0+2; resultado=0x10, Z=0, n_ops=1.
- A=3, B=3, Sel=001 (sub) -> resultado=0x00, Z=1, COUT=0; valido single cycle; pronto high the same edge.
- A=6, B=0, Sel=011 (div) -> ERR=1, resultado=0, state ERRO, pronto=0. A further iniciar is ignored (no valido); limpar -> pronto=1, ERR=0, n_ops unchanged.
- Accept A=2, B=2, Sel=000; change switches to A=F mid-EXECUTA -> ula_A stays 2; resultado=0x04.
- limpar asserted one cycle after accept -> no valido, state OCIOSO, resultado=0. rst_n pulsed low mid-EXECUTA -> all outputs 0 asynchronously, pronto=1.
- With ULA_ACUM_EN, resultado=0x04: usar_acum=1, B=5, Sel=000 -> ula_A=4, resultado=0x09. Without the macro -> ula_A=A_in.
